// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, header field positions, injector states
// and the header-flit formatter.
package noc_pkg;

  localparam int FLIT_W       = 17;
  localparam int VALID_BIT    = 16;
  localparam int PAYLOAD_W    = 16;
  localparam int ID_W         = 4;
  localparam int LEN_W        = 3;
  localparam int HDR_DEST_LSB = 12;
  localparam int HDR_SRC_LSB  = 8;
  localparam int HDR_LEN_LSB  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } inj_state_e;

  // Header: valid | dest | src | body length | five reserved zero bits.
  function automatic logic [FLIT_W-1:0] make_header(input logic [ID_W-1:0]  dest,
                                                    input logic [ID_W-1:0]  src,
                                                    input logic [LEN_W-1:0] len);
    logic [FLIT_W-1:0] f;
    f                           = '0;
    f[VALID_BIT]                = 1'b1;
    f[HDR_DEST_LSB +: ID_W]     = dest;
    f[HDR_SRC_LSB  +: ID_W]     = src;
    f[HDR_LEN_LSB  +: LEN_W]    = len;
    return f;
  endfunction

endpackage

// File: rtl/noc_packet_injector.sv
// Packet injector: turns a core packet request plus its body payload stream into
// header and body flits on the router local input, honouring back-pressure.
module noc_packet_injector
  import noc_pkg::*;
#(
  parameter logic [3:0] SRC_ID = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid_i,
  input  logic [ID_W-1:0]      pkt_dest_i,
  input  logic [LEN_W-1:0]     pkt_len_i,
  output logic                 pkt_ready_o,
  input  logic                 body_valid_i,
  input  logic [PAYLOAD_W-1:0] body_data_i,
  output logic                 body_ready_o,
  input  logic                 local_full_i,
  output logic [FLIT_W-1:0]    local_data_o,
  output logic                 busy_o,
  output logic                 pkt_sent_o
);

  inj_state_e           r_state;
  logic [ID_W-1:0]      r_dest;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_rem;
  logic [FLIT_W-1:0]    r_data;
  logic                 r_sent;

  inj_state_e           w_state_nxt;
  logic [ID_W-1:0]      w_dest_nxt;
  logic [LEN_W-1:0]     w_len_nxt;
  logic [LEN_W-1:0]     w_rem_nxt;
  logic [FLIT_W-1:0]    w_data_nxt;
  logic                 w_sent_nxt;
  logic                 w_pkt_ready;
  logic                 w_body_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dest  <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_sent  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dest  <= w_dest_nxt;
      r_len   <= w_len_nxt;
      r_rem   <= w_rem_nxt;
      r_data  <= w_data_nxt;
      r_sent  <= w_sent_nxt;
    end
  end

  // The flit register defaults to zero every cycle, so each flit lives exactly one cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_dest_nxt   = r_dest;
    w_len_nxt    = r_len;
    w_rem_nxt    = r_rem;
    w_data_nxt   = '0;
    w_sent_nxt   = 1'b0;
    w_pkt_ready  = 1'b0;
    w_body_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_pkt_ready = 1'b1;
        if (pkt_valid_i) begin
          w_dest_nxt  = pkt_dest_i;
          w_len_nxt   = pkt_len_i;
          w_state_nxt = HEAD;
        end
      end
      HEAD: begin
        if (!local_full_i) begin
          w_data_nxt = make_header(r_dest, SRC_ID, r_len);
          if (r_len == '0) begin
            w_sent_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_rem_nxt   = r_len;
            w_state_nxt = BODY;
          end
        end
      end
      BODY: begin
        w_body_ready = ~local_full_i;
        if (body_valid_i && !local_full_i && (r_rem != '0)) begin
          w_data_nxt = {1'b1, body_data_i};
          w_rem_nxt  = r_rem - 3'd1;
          if (r_rem == 3'd1) begin
            w_sent_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pkt_ready_o  = w_pkt_ready & ~rst;
  assign body_ready_o = w_body_ready & ~rst;
  assign local_data_o = r_data;
  assign pkt_sent_o   = r_sent;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector with SRC_ID=3; each scenario task checks
// flits, pulses and handshakes cycle by cycle against hand-computed values.
module tb_noc_packet_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid_i;
  logic [3:0]  pkt_dest_i;
  logic [2:0]  pkt_len_i;
  logic        pkt_ready_o;
  logic        body_valid_i;
  logic [15:0] body_data_i;
  logic        body_ready_o;
  logic        local_full_i;
  logic [16:0] local_data_o;
  logic        busy_o;
  logic        pkt_sent_o;

  int checks   = 0;
  int failures = 0;

  noc_packet_injector #(.SRC_ID(4'd3)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid_i  (pkt_valid_i),
    .pkt_dest_i   (pkt_dest_i),
    .pkt_len_i    (pkt_len_i),
    .pkt_ready_o  (pkt_ready_o),
    .body_valid_i (body_valid_i),
    .body_data_i  (body_data_i),
    .body_ready_o (body_ready_o),
    .local_full_i (local_full_i),
    .local_data_o (local_data_o),
    .busy_o       (busy_o),
    .pkt_sent_o   (pkt_sent_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pkt_valid_i = 1'b1;
    step(); step();
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL rst_data got=%h exp=%h", local_data_o, 17'h0); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (pkt_sent_o !== 1'b0) begin failures++; $display("FAIL rst_sent got=%b exp=0", pkt_sent_o); end
    checks++; if (pkt_ready_o !== 1'b0) begin failures++; $display("FAIL rst_pkt_ready got=%b exp=0", pkt_ready_o); end
    checks++; if (body_ready_o !== 1'b0) begin failures++; $display("FAIL rst_body_ready got=%b exp=0", body_ready_o); end
    rst = 1'b0; pkt_valid_i = 1'b0;
    #1;
    checks++; if (pkt_ready_o !== 1'b1) begin failures++; $display("FAIL idle_pkt_ready got=%b exp=1", pkt_ready_o); end
    step();
  endtask

  task automatic test_nominal();
    pkt_valid_i = 1'b1; pkt_dest_i = 4'd5; pkt_len_i = 3'd2;
    body_valid_i = 1'b1; body_data_i = 16'hAAAA;
    step();
    pkt_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL nom_busy got=%b exp=1", busy_o); end
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL nom_pre_head got=%h exp=%h", local_data_o, 17'h0); end
    checks++; if (pkt_ready_o !== 1'b0) begin failures++; $display("FAIL nom_head_ready got=%b exp=0", pkt_ready_o); end
    step();
    checks++; if (local_data_o !== 17'h15340) begin failures++; $display("FAIL nom_head got=%h exp=%h", local_data_o, 17'h15340); end
    checks++; if (pkt_sent_o !== 1'b0) begin failures++; $display("FAIL nom_head_sent got=%b exp=0", pkt_sent_o); end
    checks++; if (body_ready_o !== 1'b1) begin failures++; $display("FAIL nom_body_ready got=%b exp=1", body_ready_o); end
    step();
    checks++; if (local_data_o !== 17'h1AAAA) begin failures++; $display("FAIL nom_body0 got=%h exp=%h", local_data_o, 17'h1AAAA); end
    checks++; if (pkt_sent_o !== 1'b0) begin failures++; $display("FAIL nom_body0_sent got=%b exp=0", pkt_sent_o); end
    body_data_i = 16'h5555;
    step();
    checks++; if (local_data_o !== 17'h15555) begin failures++; $display("FAIL nom_body1 got=%h exp=%h", local_data_o, 17'h15555); end
    checks++; if (pkt_sent_o !== 1'b1) begin failures++; $display("FAIL nom_sent got=%b exp=1", pkt_sent_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL nom_busy_end got=%b exp=0", busy_o); end
    body_valid_i = 1'b0;
    step();
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL nom_after got=%h exp=%h", local_data_o, 17'h0); end
    checks++; if (pkt_sent_o !== 1'b0) begin failures++; $display("FAIL nom_sent_clear got=%b exp=0", pkt_sent_o); end
  endtask

  task automatic test_len0();
    pkt_valid_i = 1'b1; pkt_dest_i = 4'd2; pkt_len_i = 3'd0;
    step();
    pkt_valid_i = 1'b0;
    step();
    checks++; if (local_data_o !== 17'h12300) begin failures++; $display("FAIL len0_head got=%h exp=%h", local_data_o, 17'h12300); end
    checks++; if (pkt_sent_o !== 1'b1) begin failures++; $display("FAIL len0_sent got=%b exp=1", pkt_sent_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b exp=0", busy_o); end
    step();
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL len0_after got=%h exp=%h", local_data_o, 17'h0); end
  endtask

  task automatic test_head_stall();
    pkt_valid_i = 1'b1; pkt_dest_i = 4'd5; pkt_len_i = 3'd1; local_full_i = 1'b1;
    step();
    pkt_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL stall_head_%0d got=%h exp=%h", i, local_data_o, 17'h0); end
    end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy_o); end
    local_full_i = 1'b0;
    step();
    checks++; if (local_data_o !== 17'h15320) begin failures++; $display("FAIL stall_head got=%h exp=%h", local_data_o, 17'h15320); end
    local_full_i = 1'b1; body_valid_i = 1'b1; body_data_i = 16'h1234;
    #1;
    checks++; if (body_ready_o !== 1'b0) begin failures++; $display("FAIL stall_body_ready got=%b exp=0", body_ready_o); end
    step();
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL stall_body_hold got=%h exp=%h", local_data_o, 17'h0); end
    local_full_i = 1'b0;
    #1;
    checks++; if (body_ready_o !== 1'b1) begin failures++; $display("FAIL stall_body_ready_rel got=%b exp=1", body_ready_o); end
    step();
    checks++; if (local_data_o !== 17'h11234) begin failures++; $display("FAIL stall_body got=%h exp=%h", local_data_o, 17'h11234); end
    checks++; if (pkt_sent_o !== 1'b1) begin failures++; $display("FAIL stall_sent got=%b exp=1", pkt_sent_o); end
    body_valid_i = 1'b0;
    step();
  endtask

  task automatic test_body_gaps();
    pkt_valid_i = 1'b1; pkt_dest_i = 4'd5; pkt_len_i = 3'd2; body_valid_i = 1'b0;
    step();
    pkt_valid_i = 1'b0;
    step();
    checks++; if (local_data_o !== 17'h15340) begin failures++; $display("FAIL gap_head got=%h exp=%h", local_data_o, 17'h15340); end
    body_valid_i = 1'b1; body_data_i = 16'h1111;
    step();
    checks++; if (local_data_o !== 17'h11111) begin failures++; $display("FAIL gap_body0 got=%h exp=%h", local_data_o, 17'h11111); end
    body_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL gap_zero_%0d got=%h exp=%h", i, local_data_o, 17'h0); end
    end
    checks++; if (pkt_sent_o !== 1'b0) begin failures++; $display("FAIL gap_early_sent got=%b exp=0", pkt_sent_o); end
    body_valid_i = 1'b1; body_data_i = 16'h2222;
    step();
    checks++; if (local_data_o !== 17'h12222) begin failures++; $display("FAIL gap_body1 got=%h exp=%h", local_data_o, 17'h12222); end
    checks++; if (pkt_sent_o !== 1'b1) begin failures++; $display("FAIL gap_sent got=%b exp=1", pkt_sent_o); end
    step();
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL gap_no_dup got=%h exp=%h", local_data_o, 17'h0); end
    body_valid_i = 1'b0;
  endtask

  task automatic test_reset_midpacket();
    pkt_valid_i = 1'b1; pkt_dest_i = 4'd9; pkt_len_i = 3'd7;
    body_valid_i = 1'b1; body_data_i = 16'hBEEF;
    step();
    pkt_valid_i = 1'b0;
    step();
    checks++; if (local_data_o !== 17'h193E0) begin failures++; $display("FAIL mid_head got=%h exp=%h", local_data_o, 17'h193E0); end
    rst = 1'b1;
    #1;
    checks++; if (body_ready_o !== 1'b0) begin failures++; $display("FAIL mid_rst_body_ready got=%b exp=0", body_ready_o); end
    checks++; if (pkt_ready_o !== 1'b0) begin failures++; $display("FAIL mid_rst_pkt_ready got=%b exp=0", pkt_ready_o); end
    step();
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL mid_rst_data got=%h exp=%h", local_data_o, 17'h0); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy_o); end
    rst = 1'b0;
    step();
    checks++; if (local_data_o !== 17'h0) begin failures++; $display("FAIL mid_no_resume got=%h exp=%h", local_data_o, 17'h0); end
    checks++; if (pkt_ready_o !== 1'b1) begin failures++; $display("FAIL mid_idle_ready got=%b exp=1", pkt_ready_o); end
    body_valid_i = 1'b0;
    pkt_valid_i = 1'b1; pkt_dest_i = 4'd4; pkt_len_i = 3'd0;
    step();
    pkt_valid_i = 1'b0;
    step();
    checks++; if (local_data_o !== 17'h14300) begin failures++; $display("FAIL mid_new_head got=%h exp=%h", local_data_o, 17'h14300); end
    checks++; if (pkt_sent_o !== 1'b1) begin failures++; $display("FAIL mid_new_sent got=%b exp=1", pkt_sent_o); end
    step();
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int headers = 0;
    int bodies = 0;
    int sents = 0;
    int gap_viol = 0;
    int unexpected = 0;
    logic [16:0] prev;
    pkt_valid_i = 1'b0; body_valid_i = 1'b1; body_data_i = 16'h0001;
    pkt_dest_i = 4'd6; pkt_len_i = 3'd1;
    step();
    prev = local_data_o;
    pkt_valid_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (pkt_valid_i && pkt_ready_o) accepts++;
      step();
      if (accepts == 3) pkt_valid_i = 1'b0;
      if (local_data_o == 17'h16320) begin
        headers++;
        if (prev !== 17'h0) gap_viol++;
      end else if (local_data_o == 17'h10001) begin
        bodies++;
      end else if (local_data_o !== 17'h0) begin
        unexpected++;
      end
      if (pkt_sent_o === 1'b1) sents++;
      prev = local_data_o;
    end
    body_valid_i = 1'b0;
    checks++; if (headers !== 3) begin failures++; $display("FAIL b2b_headers got=%0d exp=3", headers); end
    checks++; if (bodies !== 3) begin failures++; $display("FAIL b2b_bodies got=%0d exp=3", bodies); end
    checks++; if (sents !== 3) begin failures++; $display("FAIL b2b_sent_count got=%0d exp=3", sents); end
    checks++; if (gap_viol !== 0) begin failures++; $display("FAIL b2b_gap got=%0d exp=0", gap_viol); end
    checks++; if (unexpected !== 0) begin failures++; $display("FAIL b2b_unexpected got=%0d exp=0", unexpected); end
  endtask

  initial begin
    rst = 1'b1; pkt_valid_i = 1'b0; pkt_dest_i = '0; pkt_len_i = '0;
    body_valid_i = 1'b0; body_data_i = '0; local_full_i = 1'b0;
    test_reset();
    test_nominal();
    test_len0();
    test_head_stall();
    test_body_gaps();
    test_reset_midpacket();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
